seq_mem_buffer: RTL and testbench
=================================

SEQ_MEM_BUFFER -- requirements
Module: seq_mem_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of the internal memory; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32, width of each stored word.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of buffer contents.
REQ-006 wr_valid  input  1  write request.
REQ-007 wr_data  input  DATA_WIDTH  word to write.
REQ-008 wr_ready  output  1  buffer can accept a word.
REQ-009 rd_valid  output  1  rd_data holds the oldest unread word.
REQ-010 rd_data  output  DATA_WIDTH  oldest unread word, registered.
REQ-011 rd_ready  input  1  consumer accepts rd_data.
REQ-012 level  output  ADDR_WIDTH+1  words written and not yet popped, range 0..DEPTH.
REQ-013 full  output  1  level == DEPTH.
REQ-014 empty  output  1  level == 0.

Function
REQ-015 Storage is a DEPTH x DATA_WIDTH inferred dual-port RAM: port A is write-only at wr_ptr, port B is read-only at rd_ptr, with a synchronous (registered) read.
REQ-016 A push occurs on a clock edge where wr_valid && wr_ready: mem[wr_ptr] <= wr_data and wr_ptr advances by 1.
REQ-017 A pop occurs on a clock edge where rd_valid && rd_ready: rd_ptr advances by 1.
REQ-018 wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-019 wr_ready = !full; there is no write-through-when-full bypass, even if a pop occurs in the same cycle.
REQ-020 level changes by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-021 Write-to-read latency when the buffer is empty: a word pushed at edge N makes rd_valid=1 with that word on rd_data after edge N+2.
REQ-022 Back-to-back pops at one word per cycle are sustained while unread words exist; rd_data shows the next word in the cycle after each pop, with no bubble.
REQ-023 rd_valid and rd_data are held stable while rd_valid && !rd_ready.
REQ-024 rd_valid = 0 whenever no written word is yet visible; rd_ready while rd_valid=0 has no effect.
REQ-025 Words are read out in exact push order; each word is popped exactly once.
REQ-026 flush=1 at an edge sets wr_ptr, rd_ptr and level to 0 and rd_valid to 0; any push or pop in that same cycle is discarded.
REQ-027 A write attempt while full (wr_valid && !wr_ready) is dropped and leaves memory and pointers unchanged.

Reset
REQ-028 reset=1 at an edge applies all flush effects and has priority over flush, push and pop.
REQ-029 After reset: wr_ready=1, rd_valid=0, rd_data=0, level=0, full=0, empty=1, and all pointers are 0.
REQ-030 RAM contents are not cleared by reset or flush.
REQ-031 Reset asserted mid-stream takes effect at the next edge; any in-flight read is discarded.

Configuration
REQ-032 Macro SEQ_MEM_BUFFER_ERR_EN, when defined, adds output overflow_err (1 bit) and output drop_count (16 bits).
REQ-033 With the macro defined: overflow_err is set sticky on every dropped write (REQ-027), and drop_count increments on every dropped write, saturating at 16'hFFFF.
REQ-034 With the macro defined: overflow_err and drop_count are cleared to 0 by reset or flush.
REQ-035 With the macro undefined: those ports and their logic do not exist, and dropped writes are silently ignored.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32)
REQ-036 After reset, push 0xA5 at edge 1 with rd_ready=0 -> rd_valid=1 and rd_data=0xA5 after edge 3; level=1.
REQ-037 Push 0..15 on consecutive cycles -> full=1 and wr_ready=0 at level 16; a 17th push is dropped; popping 16 words yields 0..15 in order, then empty=1.
REQ-038 Continuous push and pop for 40 cycles with data 100..139 -> pointers wrap twice, all 40 words are read in order, and level stays constant once the pipeline is filled.
REQ-039 Push 5 words, then assert flush in the same cycle as a push and a pop -> level=0, rd_valid=0 next cycle, and the next word pushed is the first word read.
REQ-040 With SEQ_MEM_BUFFER_ERR_EN defined: fill to 16, then attempt 3 extra writes -> overflow_err=1 and drop_count=3; reset -> both read 0.

Source files
------------

// File: rtl/seq_mem_buffer.sv
// seq_mem_buffer: FIFO on an inferred dual-port RAM with registered read data and a first-word-fall-through output stage.
// Define SEQ_MEM_BUFFER_ERR_EN to add overflow_err and drop_count outputs for dropped writes.
module seq_mem_buffer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
`ifdef SEQ_MEM_BUFFER_ERR_EN
    ,
    output logic                  overflow_err,
    output logic [15:0]           drop_count
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_d, rd_ptr;
    logic                  push, pop, fetch;

    assign full     = level == DEPTH[ADDR_WIDTH:0];
    assign empty    = level == '0;
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    // wr_ptr_d lags one cycle so a word becomes fetchable two edges after its push
    assign fetch    = (wr_ptr_d != rd_ptr) && (!rd_valid || rd_ready);

    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            wr_ptr_d <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            if (reset)
                rd_data <= '0;
        end else begin
            wr_ptr_d <= wr_ptr;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fetch) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= fetch || (rd_valid && !rd_ready);
            level    <= (push && !pop) ? level + 1'b1 : (pop && !push) ? level - 1'b1 : level;
        end
    end

`ifdef SEQ_MEM_BUFFER_ERR_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            overflow_err <= 1'b0;
            drop_count   <= '0;
        end else if (wr_valid && !wr_ready) begin
            overflow_err <= 1'b1;
            drop_count   <= (drop_count == 16'hFFFF) ? drop_count : drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_mem_buffer.sv
// tb_seq_mem_buffer: directed and random stimulus against a queue-based scoreboard model of seq_mem_buffer.
module tb_seq_mem_buffer;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, rd_valid, full, empty;
    logic [31:0] rd_data;
    logic [4:0]  level;
`ifdef SEQ_MEM_BUFFER_ERR_EN
    logic        overflow_err;
    logic [15:0] drop_count;
`endif

    int errors = 0, checks = 0, edges = 0, drops = 0;
    logic [31:0] q[$];
    int          st[$];

    seq_mem_buffer #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .level(level), .full(full), .empty(empty)
`ifdef SEQ_MEM_BUFFER_ERR_EN
        , .overflow_err(overflow_err), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Scoreboard: queue holds unpopped words with their push edge; a word is visible two edges after its push.
    always @(negedge clk) begin : mon
        logic ev;
        if (edges > 0) begin
            ev = q.size() > 0 && edges >= st[0] + 2;
            chk("level", 64'(level), 64'(q.size()));
            chk("full", 64'(full), 64'(q.size() == 16));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("wr_ready", 64'(wr_ready), 64'(q.size() != 16));
            chk("rd_valid", 64'(rd_valid), 64'(ev));
            if (ev)
                chk("rd_data", 64'(rd_data), 64'(q[0]));
`ifdef SEQ_MEM_BUFFER_ERR_EN
            chk("overflow_err", 64'(overflow_err), 64'(drops > 0));
            chk("drop_count", 64'(drop_count), 64'(drops));
`endif
            if (reset || flush) begin
                q.delete();
                st.delete();
                drops = 0;
            end else begin
                if (wr_valid && q.size() == 16 && !(drops == 65535))
                    drops++;
                if (ev && rd_ready) begin
                    void'(q.pop_front());
                    void'(st.pop_front());
                end
                if (wr_valid && (q.size() + ((ev && rd_ready) ? 1 : 0)) < 16) begin
                    q.push_back(wr_data);
                    st.push_back(edges + 1);
                end
            end
        end
    end

    task automatic cyc(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_wr_ready", 64'(wr_ready), 64'h1);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);

        cyc(1, 32'hA5, 0, 0);
        chk("lat_e1_valid", 64'(rd_valid), 64'h0);
        cyc(0, 0, 0, 0);
        chk("lat_e2_valid", 64'(rd_valid), 64'h0);
        cyc(0, 0, 0, 0);
        chk("lat_e3_valid", 64'(rd_valid), 64'h1);
        chk("lat_e3_data", 64'(rd_data), 64'hA5);
        chk("lat_e3_level", 64'(level), 64'h1);
        cyc(0, 0, 0, 0);
        chk("hold_data", 64'(rd_data), 64'hA5);
        cyc(0, 0, 1, 0);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, i, 0, 0);
        chk("fill_full", 64'(full), 64'h1);
        chk("fill_wr_ready", 64'(wr_ready), 64'h0);
        cyc(1, 32'd99, 0, 0);
        chk("drop_level", 64'(level), 64'd16);
        for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0);
        chk("drain_empty", 64'(empty), 64'h1);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 100 + i, 1, 0);
            if (i == 20) chk("stream_level", 64'(level), 64'd3);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        chk("stream_empty", 64'(empty), 64'h1);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 200 + i, 0, 0);
        cyc(1, 32'd55, 1, 1);
        chk("flush_level", 64'(level), 64'h0);
        chk("flush_valid", 64'(rd_valid), 64'h0);
        cyc(1, 32'd77, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("flush_first_data", 64'(rd_data), 64'd77);
        chk("flush_first_valid", 64'(rd_valid), 64'h1);

`ifdef SEQ_MEM_BUFFER_ERR_EN
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, i, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD, 0, 0);
        chk("err_flag", 64'(overflow_err), 64'h1);
        chk("err_count", 64'(drop_count), 64'd3);
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        chk("err_flag_rst", 64'(overflow_err), 64'h0);
        chk("err_count_rst", 64'(drop_count), 64'h0);
`endif

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 300; i++) begin
                reset = ($urandom_range(0, 399) == 0);
                cyc($urandom_range(0, 99) < 30 + b * 10, $urandom,
                    $urandom_range(0, 99) < 80 - b * 10, $urandom_range(0, 149) == 0);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 25; i++) cyc(0, 0, 1, 0);
        chk("final_empty", 64'(empty), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
